serial_adder_ctrl: RTL and testbench

//  Bit-serial add/subtract engine that reuses a single 1-bit full adder.
//  The full adder is built from two HalfAdder instances plus an OR gate.
//  An FSM sequences the adder over WIDTH cycles, LSB first, with a start/done handshake.

---
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full adder (two half adders + OR) stepped
// LSB first over WIDTH cycles, sequenced by an IDLE/RUN/DONE FSM with start/done handshake.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_adder u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] opa, opb;
  // Holds the WIDTH-1 most recent result bits; the last bit joins at the final edge.
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fs, fc;
  logic             last, accept;

  full_adder u_fa (.x(opa[0]), .y(opb[0]), .ci(carry), .s(fs), .co(fc));

  assign acc_nx = {fs, acc};
  assign last   = (cnt == CW'(WIDTH-1));
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          carry <= fc;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          acc   <= acc_nx[WIDTH-1:1];
          cnt   <= cnt + CW'(1);
          if (last) begin
            // carry still holds the carry into the MSB here
            sum   <= acc_nx;
            cout  <= fc;
            ovf   <= carry ^ fc;
            state <= DONE;
          end
        end
        IDLE, DONE: begin
          if (accept) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: arithmetic reference model with per-cycle compare on the
// WIDTH=8 instance, literal spot checks, and an exhaustive sweep on a WIDTH=4 instance.

module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst8_n = 1'b1, rst4_n = 1'b1;
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {ovf, cout, sum[31:0]} from plain integer arithmetic.
  function automatic logic [33:0] calc(input int w, input int a, input int b, input bit sub);
    int mask = (1 << w) - 1;
    int half = 1 << (w - 1);
    int t    = sub ? (a + ((~b) & mask) + 1) : (a + b);
    int sa   = (a >= half) ? a - (1 << w) : a;
    int sb   = (b >= half) ? b - (1 << w) : b;
    int r    = sub ? sa - sb : sa + sb;
    bit o    = (r < -half) || (r >= half);
    bit c    = ((t >> w) & 1) != 0;
    return {o, c, 32'(t & mask)};
  endfunction

  // Transaction-level model of the WIDTH=8 instance.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [33:0] m_res = '0, p_res = '0;

  always @(posedge clk or negedge rst8_n) begin
    if (!rst8_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_res <= p_res;
    end else begin
      m_done <= 1'b0;
      if (start8) begin
        p_res  <= calc(8, int'(a8), int'(b8), sub8);
        m_left <= 8;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy8), 32'(m_left > 0));
      check("done", 32'(done8), 32'(m_done));
      check("sum",  32'(sum8),  32'(m_res[7:0]));
      check("cout", 32'(cout8), 32'(m_res[32]));
      check("ovf",  32'(ovf8),  32'(m_res[33]));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit poke,
                     output logic [7:0] rs, output logic rc, output logic ro,
                     output int lat, output int busyc);
    @(negedge clk); #1;
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    lat = 1; busyc = int'(busy8);
    while (!done8 && lat < 40) begin
      #1;
      start8 = poke && (lat == 3);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      @(negedge clk);
      lat++; busyc += int'(busy8);
    end
    #1 start8 = 1'b0;
    check("done8_timeout", 32'(done8), 32'd1);
    rs = sum8; rc = cout8; ro = ovf8;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int n = 0;
    logic [33:0] e;
    @(negedge clk); #1;
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    @(negedge clk); #1 start4 = 1'b0;
    while (!done4 && n < 20) begin @(negedge clk); n++; end
    check("done4_timeout", 32'(done4), 32'd1);
    e = calc(4, int'(a), int'(b), s);
    check("w4_result", {26'd0, ovf4, cout4, sum4}, {26'd0, e[33], e[32], e[3:0]});
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc, ro;
    int         lat, busyc, nd, prev, gap_bad;

    // Model pinned to hand-computed values
    check("model_add", 32'(calc(8, 'h0F, 'h01, 0) & 34'h3_FFFF_FFFF), 32'h10);
    check("model_sub", 32'(calc(8, 'h05, 'h07, 1) >> 32), 32'h0);
    check("model_ovf", 32'(calc(8, 'h80, 'h01, 1) >> 32), 32'h3);

    #2 rst8_n = 1'b0; rst4_n = 1'b0;
    @(negedge clk); #1;
    check("rst_outs", {busy8, done8, sum8, cout8, ovf8}, '0);
    chk_en = 1'b1;
    @(negedge clk); #1 rst8_n = 1'b1; rst4_n = 1'b1;

    op8(8'h0F, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat, busyc);
    check("t1_sum", 32'(rs), 32'h10); check("t1_cout", 32'(rc), 0); check("t1_ovf", 32'(ro), 0);
    check("t1_latency", 32'(lat), 9); check("t1_busy_cycles", 32'(busyc), 8);

    op8(8'hFF, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat, busyc);
    check("t2a", {rs, rc, ro}, {8'h00, 1'b1, 1'b0});
    op8(8'h7F, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat, busyc);
    check("t2b", {rs, rc, ro}, {8'h80, 1'b0, 1'b1});

    op8(8'h05, 8'h07, 1'b1, 1'b0, rs, rc, ro, lat, busyc);
    check("t3a", {rs, rc, ro}, {8'hFE, 1'b0, 1'b0});
    op8(8'h80, 8'h01, 1'b1, 1'b0, rs, rc, ro, lat, busyc);
    check("t3b", {rs, rc, ro}, {8'h7F, 1'b1, 1'b1});

    // start and operands churned mid-run must not disturb the latched operation
    op8(8'h33, 8'h44, 1'b0, 1'b1, rs, rc, ro, lat, busyc);
    check("t4_ignore", {rs, rc, ro}, {8'h77, 1'b0, 1'b0});
    check("t4_latency", 32'(lat), 9);

    // start held high: done every WIDTH+1 cycles
    @(negedge clk); #1 a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
    nd = 0; prev = 0; gap_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        if (nd > 0 && cyc - prev != 9) gap_bad++;
        prev = cyc; nd++;
      end
    end
    #1 start8 = 1'b0;
    check("t4_held_pulses", 32'(nd), 4);
    check("t4_held_gap", 32'(gap_bad), 0);
    repeat (12) @(negedge clk);

    // Reset in the middle of a run
    @(negedge clk); #1 a8 = 8'hAA; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk); #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst8_n = 1'b0;
    #1 check("t5_rst_outs", {busy8, done8, sum8, cout8, ovf8}, '0);
    nd = 0;
    repeat (10) begin @(negedge clk); nd += int'(done8); end
    check("t5_no_done", 32'(nd), 0);
    #1 rst8_n = 1'b1;
    op8(8'hAA, 8'h11, 1'b0, 1'b0, rs, rc, ro, lat, busyc);
    check("t5_after", {rs, rc, ro}, {8'hBB, 1'b0, 1'b0});

    // Random traffic against the model
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk); #1;
      start8 = ($urandom_range(0, 3) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    end
    #1 start8 = 1'b0;
    repeat (12) @(negedge clk);

    // Exhaustive WIDTH=4
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op4(4'(x), 4'(y), 1'(s));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
